aes128_cipher_loader: RTL

Upstream front end for the AES-128 decryption core. Accepts ciphertext one byte per cycle over a valid/ready handshake and packs 16 bytes into a 128-bit block, first byte in the most significant position. Holds the block stable on the core's data input until the next block is complete. Holds off input during the core's post-reset key-generation window, and emits a latency-matched valid flag that marks when the core output holds the plaintext for each loaded block.

---
 rtl/aes128_cipher_loader.sv | 55 +++++
 1 files changed

// File: rtl/aes128_cipher_loader.sv
// aes128_cipher_loader: packs ciphertext bytes into 128-bit blocks for the AES-128 core, with warm-up hold-off and a latency-matched plaintext valid
module aes128_cipher_loader #(
    parameter int WARMUP = 22,
    parameter int LATENCY = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    output logic         byte_ready,
    output logic [127:0] block_out,
    output logic         block_strobe,
    output logic         pt_valid,
    output logic [15:0]  block_count
);
    typedef enum logic {WARM, FILL} state_t;
    state_t state, state_nx;
    logic [7:0] warm_cnt;
    logic [3:0] byte_idx;
    logic [119:0] acc;
    logic [LATENCY-1:0] tag;
    logic accept, last;
    always_comb begin
        byte_ready = state == FILL;
        accept = byte_valid && byte_ready;
        last = accept && byte_idx == 4'd15;
        state_nx = (state == WARM && warm_cnt == 8'(WARMUP - 1)) ? FILL : state;
    end
    assign pt_valid = tag[LATENCY-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WARM;
            warm_cnt <= '0;
            byte_idx <= '0;
            acc <= '0;
            block_out <= '0;
            block_strobe <= 1'b0;
            tag <= '0;
            block_count <= '0;
        end else begin
            state <= state_nx;
            warm_cnt <= (state == WARM) ? warm_cnt + 8'd1 : warm_cnt;
            block_strobe <= last;
            tag <= LATENCY'({tag, block_strobe});
            if (accept) begin
                acc <= {acc[111:0], byte_in};
                byte_idx <= byte_idx + 4'd1;
            end
            if (last) begin
                block_out <= {acc, byte_in};
                block_count <= block_count + 16'd1;
            end
        end
    end
endmodule
